// File: rtl/mem_port_arbiter_pkg.sv
// arb_defs: shared state/owner encodings and default limits for the memory port arbiter
package arb_defs;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;
    localparam int DEF_MAX_DATA_RUN = 4;
    localparam int DEF_TIMEOUT      = 31;
endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// arb_sat_counter: saturating up-counter with synchronous clear and terminal-count flag
module arb_sat_counter #(
    parameter int W     = 3,
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);
    logic [W-1:0] cnt_q, cnt_d;

    // clear wins over increment; increment stops at LIMIT
    always_comb begin
        cnt_d = clr ? '0 : (inc && cnt_q != W'(LIMIT)) ? cnt_q + W'(1) : cnt_q;
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tc = (cnt_q == W'(LIMIT));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one multi-cycle memory port between fetch and data requesters
module mem_port_arbiter import arb_defs::*; #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MAX_DATA_RUN = DEF_MAX_DATA_RUN,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fReq,
    input  logic [ADDR_W-1:0] fAddr,
    input  logic              dReq,
    input  logic              dWr,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dWrData,
    output logic              fStall,
    output logic              dStall,
    output logic              fDone,
    output logic              dDone,
    output logic [DATA_W-1:0] rdData,
    output logic              memEn,
    output logic              memWr,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWrData,
    input  logic              memDone,
    input  logic [DATA_W-1:0] memRdData,
    output logic              err
);
    localparam int RUN_W  = $clog2(MAX_DATA_RUN + 1);
    localparam int BUSY_W = $clog2(TIMEOUT + 1);

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic in_issue, in_wait, done, f_done, d_done, f_elig, d_elig;
    logic decide, grant, grant_data, run_tc, busy_tc, timeout, req_drop;

    // grant decision, next-state and sticky error detection
    always_comb begin
        in_issue   = (state_q == ISSUE);
        in_wait    = (state_q == WAIT);
        timeout    = in_wait & ~memDone & busy_tc;
        done       = ~rst & in_wait & (memDone | busy_tc);
        f_done     = done & (owner_q == OWN_FETCH);
        d_done     = done & (owner_q == OWN_DATA);
        f_elig     = fReq & ~f_done;
        d_elig     = dReq & ~d_done;
        decide     = (state_q == IDLE) | (in_wait & memDone);
        grant      = decide & (f_elig | d_elig);
        grant_data = d_elig & ~(run_tc & f_elig);
        req_drop   = (in_issue | in_wait) & ~((owner_q == OWN_DATA) ? dReq : fReq);
        state_d    = grant ? ISSUE : (in_issue | (in_wait & ~done)) ? WAIT : IDLE;
        owner_d    = grant ? (grant_data ? OWN_DATA : OWN_FETCH) : owner_q;
        addr_d     = grant ? (grant_data ? dAddr : fAddr) : addr_q;
        wr_d       = grant ? (grant_data & dWr) : wr_q;
        wdata_d    = grant ? (grant_data ? dWrData : '0) : wdata_q;
        err_d      = err_q | (memDone & ((state_q == IDLE) | in_issue)) | timeout
                   | (grant & addr_d[0]) | req_drop;
    end

    // transaction registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_FETCH;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    arb_sat_counter #(.W(RUN_W), .LIMIT(MAX_DATA_RUN)) u_run (
        .clk(clk), .rst(rst),
        .clr(grant & (~grant_data | ~fReq)),
        .inc(grant & grant_data & fReq),
        .tc(run_tc)
    );

    arb_sat_counter #(.W(BUSY_W), .LIMIT(TIMEOUT)) u_busy (
        .clk(clk), .rst(rst),
        .clr(grant),
        .inc(state_q != IDLE),
        .tc(busy_tc)
    );

    assign fDone     = f_done;
    assign dDone     = d_done;
    assign fStall    = fReq & ~f_done;
    assign dStall    = dReq & ~d_done;
    assign rdData    = (done & memDone) ? memRdData : '0;
    assign memEn     = in_issue;
    assign memWr     = wr_q & (state_q != IDLE);
    assign memAddr   = addr_q;
    assign memWrData = wdata_q;
    assign err       = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a transaction-level arbitration and memory model
module tb_mem_port_arbiter;
    localparam int TIMEOUT = 31;
    localparam int MAX     = 4;

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [15:0] wdata;
        int          gap;
    } req_t;

    logic clk = 1'b0;
    logic rst;
    logic fReq, dReq, dWr, memDone;
    logic [15:0] fAddr, dAddr, dWrData, memRdData;
    logic fStall, dStall, fDone, dDone, memEn, memWr, err;
    logic [15:0] rdData, memAddr, memWrData;

    req_t fstim[$], dstim[$], fq[$], dq[$];
    int total = 0, bad = 0;
    bit m_issue, m_wait, m_err, m_own, f_last_done, d_last_done, hang, inject;
    int m_wcnt, m_run, fix_lat, mcnt;
    req_t m_cur;
    logic [15:0] maddr;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .fReq(fReq), .fAddr(fAddr),
        .dReq(dReq), .dWr(dWr), .dAddr(dAddr), .dWrData(dWrData),
        .fStall(fStall), .dStall(dStall), .fDone(fDone), .dDone(dDone),
        .rdData(rdData), .memEn(memEn), .memWr(memWr), .memAddr(memAddr),
        .memWrData(memWrData), .memDone(memDone), .memRdData(memRdData), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    // fetch requester: presents queued requests, holds each until fDone
    initial begin
        int gap;
        req_t s;
        gap = 0; fReq = 1'b0; fAddr = '0;
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                fReq = 1'b0; gap = 0;
            end else begin
                if (fReq && f_last_done) fReq = 1'b0;
                if (!fReq && fstim.size() > 0) begin
                    if (gap < fstim[0].gap) gap++;
                    else begin
                        s = fstim.pop_front();
                        fAddr = s.addr; fReq = 1'b1; fq.push_back(s); gap = 0;
                    end
                end
            end
        end
    end

    // data requester: presents queued loads/stores, holds each until dDone
    initial begin
        int gap;
        req_t s;
        gap = 0; dReq = 1'b0; dWr = 1'b0; dAddr = '0; dWrData = '0;
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                dReq = 1'b0; gap = 0;
            end else begin
                if (dReq && d_last_done) dReq = 1'b0;
                if (!dReq && dstim.size() > 0) begin
                    if (gap < dstim[0].gap) gap++;
                    else begin
                        s = dstim.pop_front();
                        dAddr = s.addr; dWr = s.wr; dWrData = s.wdata; dReq = 1'b1;
                        dq.push_back(s); gap = 0;
                    end
                end
            end
        end
    end

    // monitor + reference model + memory model
    initial begin
        bit dn, fd, dd, ok_done, idle, fe, de, gd, nerr;
        memDone = 1'b0; memRdData = '0; mcnt = 0; maddr = '0;
        m_issue = 0; m_wait = 0; m_err = 0; m_own = 0; m_wcnt = 0; m_run = 0;
        f_last_done = 0; d_last_done = 0;
        m_cur = '{16'h0, 1'b0, 16'h0, 0};
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_fDone", fDone, 1'b0);
                chk("rst_dDone", dDone, 1'b0);
                m_issue = 0; m_wait = 0; m_err = 0; m_run = 0; m_wcnt = 0; mcnt = 0;
                fq.delete(); dq.delete();
                f_last_done = 0; d_last_done = 0;
            end else begin
                ok_done = m_wait && memDone;
                dn = ok_done || (m_wait && m_wcnt == TIMEOUT);
                fd = dn && !m_own;
                dd = dn && m_own;
                idle = !m_issue && !m_wait;
                chk("memEn", memEn, m_issue);
                if (m_issue) begin
                    chk("memAddr", memAddr, m_cur.addr);
                    chk("memWr", memWr, m_own && m_cur.wr);
                    if (m_own) chk("memWrData", memWrData, m_cur.wdata);
                end
                chk("fDone", fDone, fd);
                chk("dDone", dDone, dd);
                chk("fStall", fStall, fReq && !fd);
                chk("dStall", dStall, dReq && !dd);
                chk("err", err, m_err);
                chk("rdData", rdData, ok_done ? (m_cur.addr ^ 16'h5A5A) : 16'h0);
                nerr = m_err || (memDone && !m_wait) || (dn && !ok_done)
                     || ((m_issue || m_wait) && !(m_own ? dReq : fReq));
                if (fd && fq.size() > 0) void'(fq.pop_front());
                if (dd && dq.size() > 0) void'(dq.pop_front());
                if (memEn && !hang) begin
                    mcnt = (fix_lat > 0) ? fix_lat : int'($urandom_range(1, 4));
                    maddr = memAddr;
                end
                if (m_issue) begin
                    m_issue = 0; m_wait = 1; m_wcnt = 1;
                end else if (m_wait) begin
                    if (dn) m_wait = 0;
                    else m_wcnt++;
                end
                if (idle || ok_done) begin
                    fe = fReq && !fd;
                    de = dReq && !dd;
                    if (fe || de) begin
                        gd = de && !(m_run == MAX && fe);
                        if ((gd ? dq.size() : fq.size()) == 0) begin
                            total++; bad++;
                            $display("FAIL grant_source got=empty want=pending at %0t", $time);
                        end else m_cur = gd ? dq[0] : fq[0];
                        m_own = gd;
                        m_run = (gd && fReq) ? ((m_run < MAX) ? m_run + 1 : MAX) : 0;
                        nerr = nerr || m_cur.addr[0];
                        m_issue = 1; m_wait = 0;
                    end
                end
                m_err = nerr;
                f_last_done = fDone;
                d_last_done = dDone;
            end
            @(posedge clk); #3;
            memDone = 1'b0;
            if (!rst && mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) memDone = 1'b1;
            end
            if (inject) begin
                memDone = 1'b1; inject = 0;
            end
            memRdData = memDone ? (maddr ^ 16'h5A5A) : 16'($urandom);
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(fstim.size() == 0 && dstim.size() == 0 && fq.size() == 0 && dq.size() == 0
                 && !m_issue && !m_wait && !fReq && !dReq) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            total++; bad++;
            $display("FAIL idle_wait got=%0d cycles want=<%0d", n, budget);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; fix_lat = 0; hang = 0; inject = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_memEn", memEn, 1'b0);
        chk("rst_memWr", memWr, 1'b0);
        chk("rst_memAddr", memAddr, 16'h0);
        chk("rst_memWrData", memWrData, 16'h0);
        chk("rst_rdData", rdData, 16'h0);
        chk("rst_err", err, 1'b0);
        chk("rst_fStall", fStall, fReq);
        @(posedge clk); #1 rst = 1'b0;

        fix_lat = 2;
        fstim.push_back('{16'h0010, 1'b0, 16'h0, 0});
        wait_idle(200);

        @(posedge clk); #1 fix_lat = 3;
        dstim.push_back('{16'h0020, 1'b1, 16'hBEEF, 0});
        fstim.push_back('{16'h0030, 1'b0, 16'h0, 0});
        wait_idle(200);

        @(posedge clk); #1 fix_lat = 1;
        for (int i = 0; i < 6; i++) dstim.push_back('{16'h0100 + 16'(i * 2), 1'(i % 2), 16'h1000 + 16'(i), 0});
        for (int i = 0; i < 3; i++) fstim.push_back('{16'h0200 + 16'(i * 2), 1'b0, 16'h0, 0});
        wait_idle(400);

        @(posedge clk); #1 inject = 1;
        repeat (3) @(negedge clk);
        do_reset();
        fix_lat = 2;
        fstim.push_back('{16'h0011, 1'b0, 16'h0, 0});
        wait_idle(200);

        do_reset();
        hang = 1;
        dstim.push_back('{16'h0040, 1'b0, 16'h0, 0});
        wait_idle(200);
        @(posedge clk); #1 hang = 0;
        repeat (5) @(negedge clk);
        do_reset();
        fstim.push_back('{16'h0044, 1'b0, 16'h0, 0});
        wait_idle(200);

        @(posedge clk); #1 hang = 1;
        dstim.push_back('{16'h0050, 1'b1, 16'h1234, 0});
        repeat (6) @(posedge clk);
        do_reset();
        hang = 0;
        dstim.push_back('{16'h0052, 1'b0, 16'h0, 0});
        wait_idle(200);

        @(posedge clk); #1 fix_lat = 0;
        for (int i = 0; i < 150; i++) begin
            fstim.push_back('{16'($urandom) & 16'hFFFE, 1'b0, 16'h0, int'($urandom_range(0, 3))});
            dstim.push_back('{16'($urandom) & 16'hFFFE, 1'($urandom), 16'($urandom), int'($urandom_range(0, 3))});
        end
        wait_idle(20000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end
endmodule
